// File: rtl/kamus_issue_ctrl.sv
// Issue controller between ID and EX: register scoreboard, in-flight limit,
// serialising drain FSM and branch-flush kill of the presented instruction.
module kamus_issue_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 rs1_used_i,
  input  logic                 rs2_used_i,
  input  logic                 rd_write_i,
  input  logic                 is_serial_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  input  logic                 retire_i,
  input  logic                 retire_rd_write_i,
  input  logic [4:0]           retire_rd_addr_i,
  input  logic                 flush_i,
  output logic [3:0]           inflight_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [3:0] MaxInflight = 4'(MAX_INFLIGHT);

  state_e               state_q, state_d;
  logic [31:0]          sb_q, sb_d;
  logic [3:0]           inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 hazard, full, issue;

  // Hazard sees only the registered scoreboard, so a same-cycle retire
  // unblocks the dependent one cycle later.
  assign hazard = (rs1_used_i & sb_q[rs1_addr_i]) |
                  (rs2_used_i & sb_q[rs2_addr_i]) |
                  (rd_write_i & sb_q[rd_addr_i]);
  assign full   = (inflight_q == MaxInflight);

  always_comb begin
    ex_valid_o = 1'b0;
    state_d    = state_q;
    unique case (state_q)
      S_IDLE: begin
        ex_valid_o = id_valid_i & ~is_serial_i & ~hazard & ~full & ~flush_i;
        if (id_valid_i & is_serial_i & ~flush_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        ex_valid_o = id_valid_i & (inflight_q == 4'd0) & ~flush_i;
        if (ex_valid_o & ex_ready_i)      state_d = S_WAIT;
        else if (flush_i | ~id_valid_i)   state_d = S_IDLE;
      end
      S_WAIT: begin
        if (inflight_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign id_ready_o = ex_valid_o & ex_ready_i;
  assign issue      = id_ready_o;

  always_comb begin
    sb_d = sb_q;
    if (retire_i & retire_rd_write_i & (retire_rd_addr_i != 5'd0))
      sb_d[retire_rd_addr_i] = 1'b0;
    // Applied after the clear so a simultaneous set of the same register wins.
    if (issue & rd_write_i & (rd_addr_i != 5'd0))
      sb_d[rd_addr_i] = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, retire_i})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   if (inflight_q != 4'd0) inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (id_valid_i & ~id_ready_o & ~flush_i) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      sb_q       <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
    end
  end

  assign inflight_o  = inflight_q;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_kamus_issue_ctrl.sv
// Scoreboard bench for kamus_issue_ctrl: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_kamus_issue_ctrl;

  localparam int MAXI = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        id_valid_i = 1'b0, id_ready_o;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
  logic        rs1_used_i = 1'b0, rs2_used_i = 1'b0, rd_write_i = 1'b0;
  logic        is_serial_i = 1'b0, ex_valid_o, ex_ready_i = 1'b0;
  logic        retire_i = 1'b0, retire_rd_write_i = 1'b0;
  logic [4:0]  retire_rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic [3:0]  inflight_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;

  kamus_issue_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .rd_write_i(rd_write_i),
    .is_serial_i(is_serial_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .retire_i(retire_i), .retire_rd_write_i(retire_rd_write_i),
    .retire_rd_addr_i(retire_rd_addr_i), .flush_i(flush_i),
    .inflight_o(inflight_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit v, ser;
    bit [4:0] a1, a2, ad;
    bit u1, u2, w, exr, ret, rw;
    bit [4:0] ra;
    bit fl;
  } in_t;

  typedef struct {
    int cyc;
    bit exv, rdy;
    int infl, st;
    bit [31:0] stall;
  } stat_t;

  stat_t       sq[$];
  int          iq[$];
  int unsigned rdq[$];

  int passed = 0, total = 0, cyc = 0;

  // Reference model state: which registers have a pending writer, how many
  // instructions are outstanding, and where the serialisation sequence is.
  bit [31:0] m_pend;
  int        m_cnt, m_mode;
  bit [31:0] m_stall;
  bit        m_last_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    else
      passed++;
  endtask

  always @(negedge clk_i) begin : monitor
    stat_t s;
    int c;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("ex_valid", 64'(ex_valid_o), 64'(s.exv));
      chk("id_ready", 64'(id_ready_o), 64'(s.rdy));
      chk("inflight", 64'(inflight_o), 64'(s.infl));
      chk("state",    64'(state_o),    64'(s.st));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(s.stall));
      if (id_ready_o === 1'b1) begin
        if (iq.size() == 0) chk("issue_unexpected", 64'(s.cyc), 64'hFFFF_FFFF);
        else begin
          c = iq.pop_front();
          chk("issue_cycle", 64'(s.cyc), 64'(c));
        end
      end
    end
  end

  task automatic apply(input in_t x);
    id_valid_i = x.v; is_serial_i = x.ser;
    rs1_addr_i = x.a1; rs2_addr_i = x.a2; rd_addr_i = x.ad;
    rs1_used_i = x.u1; rs2_used_i = x.u2; rd_write_i = x.w;
    ex_ready_i = x.exr; retire_i = x.ret; retire_rd_write_i = x.rw;
    retire_rd_addr_i = x.ra; flush_i = x.fl;
  endtask

  task automatic model_reset();
    m_pend = '0; m_cnt = 0; m_mode = 0; m_stall = '0; m_last_rdy = 0;
    rdq.delete();
  endtask

  // One cycle: drive inputs after the edge, predict outputs, advance model.
  task automatic cyc_do(input in_t x);
    bit hz, exv, rdy;
    int nmode;
    stat_t s;
    @(posedge clk_i); #1;
    cyc++;
    apply(x);
    hz = (x.u1 && m_pend[x.a1]) || (x.u2 && m_pend[x.a2]) || (x.w && m_pend[x.ad]);
    exv = 0; nmode = m_mode;
    if (m_mode == 0) begin
      exv = x.v && !x.ser && !hz && (m_cnt != MAXI) && !x.fl;
      if (x.v && x.ser && !x.fl) nmode = 1;
    end else if (m_mode == 1) begin
      exv = x.v && (m_cnt == 0) && !x.fl;
      if (exv && x.exr) nmode = 2;
      else if (x.fl || !x.v) nmode = 0;
    end else if (m_cnt == 0) nmode = 0;
    rdy = exv && x.exr;
    s.cyc = cyc; s.exv = exv; s.rdy = rdy;
    s.infl = m_cnt; s.st = m_mode; s.stall = m_stall;
    sq.push_back(s);
    if (rdy) begin
      iq.push_back(cyc);
      rdq.push_back({26'd0, x.w, x.ad});
    end
    if (x.ret && x.rw && x.ra != 0) m_pend[x.ra] = 1'b0;
    if (rdy && x.w && x.ad != 0)    m_pend[x.ad] = 1'b1;
    if (rdy && !x.ret) m_cnt++;
    else if (!rdy && x.ret && m_cnt > 0) m_cnt--;
    if (x.v && !rdy && !x.fl) m_stall++;
    m_mode = nmode;
    m_last_rdy = rdy;
  endtask

  task automatic do_reset();
    stat_t s;
    in_t z;
    z = '{default: 0};
    @(posedge clk_i); #1;
    cyc++;
    apply(z);
    rst_ni = 1'b0;
    model_reset();
    s = '{cyc: cyc, exv: 0, rdy: 0, infl: 0, st: 0, stall: '0};
    sq.push_back(s);
    cyc_do(z);
    rst_ni = 1'b1;
  endtask

  function automatic in_t ins(input bit [4:0] a1, a2, ad, input bit u1, u2, w, ser);
    in_t x;
    x = '{default: 0};
    x.v = 1; x.exr = 1; x.ser = ser;
    x.a1 = a1; x.a2 = a2; x.ad = ad; x.u1 = u1; x.u2 = u2; x.w = w;
    return x;
  endfunction

  function automatic in_t idle_ret(input bit rw, input bit [4:0] ra);
    in_t x;
    x = '{default: 0};
    x.exr = 1; x.ret = 1; x.rw = rw; x.ra = ra;
    return x;
  endfunction

  initial begin
    in_t x, cur;
    int unsigned e;
    model_reset();
    do_reset();

    // RAW: x6 <- x5 stalls until x5 retires, issues the cycle after
    x = ins(1, 2, 5, 1, 1, 1, 0); cyc_do(x);
    x = ins(5, 1, 6, 1, 1, 1, 0);
    repeat (3) cyc_do(x);
    x.ret = 1; x.rw = 1; x.ra = 5; cyc_do(x);
    x.ret = 0; cyc_do(x);
    cyc_do(idle_ret(1, 6));

    // in-flight limit
    x = ins(0, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc_do(x);
    x.ret = 1; cyc_do(x);
    x.ret = 0; cyc_do(x);
    repeat (4) cyc_do(idle_ret(0, 0));

    // serial drain with two older instructions in flight
    x = ins(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc_do(x);
    x = ins(0, 0, 0, 0, 0, 0, 1);
    cyc_do(x);
    x.ret = 1; repeat (2) cyc_do(x);
    x.ret = 0; cyc_do(x);
    cyc_do(idle_ret(0, 0));
    x = ins(0, 0, 0, 0, 0, 0, 0); cyc_do(x);
    cyc_do(idle_ret(0, 0));

    // flush while draining
    x = ins(0, 0, 0, 0, 0, 0, 0); cyc_do(x);
    x = ins(0, 0, 0, 0, 0, 0, 1); repeat (2) cyc_do(x);
    x.fl = 1; cyc_do(x);
    cyc_do(idle_ret(0, 0));

    // set of x7 and retire of x7 in the same cycle: set wins
    x = ins(0, 0, 7, 0, 0, 1, 0);
    x.ret = 1; x.rw = 1; x.ra = 7; cyc_do(x);
    x = ins(7, 0, 8, 1, 0, 1, 0); repeat (2) cyc_do(x);
    x.ret = 1; x.rw = 1; x.ra = 7; cyc_do(x);
    x.ret = 0; cyc_do(x);
    cyc_do(idle_ret(1, 8));

    // reset while waiting for a serial instruction
    x = ins(0, 0, 9, 0, 0, 1, 1); repeat (2) cyc_do(x);
    x = ins(9, 0, 0, 1, 0, 0, 0); x.v = 0; cyc_do(x);
    do_reset();
    x = ins(9, 0, 3, 1, 0, 1, 0); cyc_do(x);
    cyc_do(idle_ret(1, 3));

    // random traffic
    do_reset();
    cur = ins(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!(cur.v && !m_last_rdy && !cur.fl && ($urandom % 100) < 85)) begin
        cur.v = ($urandom % 10) < 8;
        cur.ser = ($urandom % 12) == 0;
        cur.a1 = 5'($urandom % 8); cur.a2 = 5'($urandom % 8); cur.ad = 5'($urandom % 8);
        cur.u1 = 1'($urandom); cur.u2 = 1'($urandom); cur.w = 1'($urandom);
      end
      cur.exr = ($urandom % 10) < 8;
      cur.fl  = ($urandom % 10) == 0;
      cur.ret = 0; cur.rw = 0; cur.ra = 0;
      if (rdq.size() > 0 && ($urandom % 3) == 0) begin
        e = rdq.pop_front();
        cur.ret = 1; cur.rw = e[5]; cur.ra = e[4:0];
      end
      cyc_do(cur);
    end

    @(negedge clk_i);
    @(negedge clk_i);
    chk("pending_issues", 64'(iq.size()), 64'd0);
    chk("pending_status", 64'(sq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
